// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM states,
// decode constants and the status values written to rstatus.
package md_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2,
      ST_DONE  = 2'd3
   } md_state_t;

   localparam logic [4:0]  OP_RTYPE    = 5'b00000;
   localparam logic [4:0]  AOP_MUL     = 5'b00110;
   localparam logic [4:0]  AOP_DIV     = 5'b00111;
   localparam logic [4:0]  RSTATUS_REG = 5'd30;
   localparam logic [31:0] EXC_MUL     = 32'd4;
   localparam logic [31:0] EXC_DIV     = 32'd5;

endpackage

// File: rtl/md_cycle_counter.sv
// Busy-cycle counter for the sequencer; flags the last cycle before the
// operation is abandoned.
module md_cycle_counter
   import md_pkg::*;
#(
   parameter int CNT_W          = 6,
   parameter int TIMEOUT_CYCLES = 40
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign terminal = (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/md_sequencer.sv
// Execute-stage sequencer for the shared multi-cycle multiply/divide unit:
// issues a start pulse, stalls until ready or timeout, then writes back once.
module md_sequencer
   import md_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 40,
   parameter int CNT_W          = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        valid,
   input  logic [4:0]  opcode,
   input  logic [4:0]  aluop,
   input  logic [4:0]  rd,
   input  logic [31:0] operandA,
   input  logic [31:0] operandB,
   input  logic        flush,
   output logic        md_ctrl_mult,
   output logic        md_ctrl_div,
   output logic [31:0] md_opA,
   output logic [31:0] md_opB,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   input  logic        md_resultRDY,
   output logic        stall,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        timeout
);

   md_state_t   state_reg, state_next;
   logic        op_div_reg;
   logic [4:0]  rd_reg;
   logic [31:0] result_reg;
   logic        exc_reg;

   logic md_req, accept, capture, cnt_clear, cnt_en, terminal;

   assign md_req = valid & (opcode == OP_RTYPE) & ((aluop == AOP_MUL) | (aluop == AOP_DIV));

   md_cycle_counter #(
      .CNT_W          (CNT_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_counter (
      .clock    (clock),
      .reset    (reset),
      .clear    (cnt_clear),
      .enable   (cnt_en),
      .terminal (terminal)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      stall        = 1'b0;
      md_ctrl_mult = 1'b0;
      md_ctrl_div  = 1'b0;
      timeout      = 1'b0;
      wb_valid     = 1'b0;
      wb_rd        = '0;
      wb_data      = '0;
      accept       = 1'b0;
      capture      = 1'b0;
      cnt_clear    = 1'b0;
      cnt_en       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            // The reset term keeps the combinational stall low while reset is held.
            if (md_req && !flush && reset) begin
               stall      = 1'b1;
               accept     = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            stall        = 1'b1;
            cnt_clear    = 1'b1;
            md_ctrl_mult = ~op_div_reg;
            md_ctrl_div  = op_div_reg;
            state_next   = flush ? ST_IDLE : ST_BUSY;
         end
         ST_BUSY: begin
            stall  = 1'b1;
            cnt_en = 1'b1;
            if (flush) begin
               state_next = ST_IDLE;
            end else if (md_resultRDY) begin
               capture    = 1'b1;
               state_next = ST_DONE;
            end else if (terminal) begin
               timeout    = 1'b1;
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
            if (exc_reg) begin
               wb_valid = 1'b1;
               wb_rd    = RSTATUS_REG;
               wb_data  = op_div_reg ? EXC_DIV : EXC_MUL;
            end else begin
               wb_valid = (rd_reg != 5'd0);
               wb_rd    = rd_reg;
               wb_data  = result_reg;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         md_opA     <= '0;
         md_opB     <= '0;
         rd_reg     <= '0;
         op_div_reg <= 1'b0;
         result_reg <= '0;
         exc_reg    <= 1'b0;
      end else begin
         if (accept) begin
            md_opA     <= operandA;
            md_opB     <= operandB;
            rd_reg     <= rd;
            op_div_reg <= (aluop == AOP_DIV);
         end
         // Every path into DONE rewrites exc_reg, so no stale flag survives.
         if (capture) begin
            result_reg <= md_result;
            exc_reg    <= md_exception;
         end else if (timeout) begin
            exc_reg <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: a negedge monitor logs pulses, stalls and
// writebacks; each scenario compares the logged deltas with hand-worked values.
module tb_md_sequencer;
   import md_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        valid = 1'b0;
   logic [4:0]  opcode = '0;
   logic [4:0]  aluop = '0;
   logic [4:0]  rd = '0;
   logic [31:0] operandA = '0;
   logic [31:0] operandB = '0;
   logic        flush = 1'b0;
   logic [31:0] md_result = '0;
   logic        md_exception = 1'b0;
   logic        md_resultRDY = 1'b0;
   logic        md_ctrl_mult, md_ctrl_div, stall, wb_valid, timeout;
   logic [31:0] md_opA, md_opB, wb_data;
   logic [4:0]  wb_rd;

   md_sequencer #(.TIMEOUT_CYCLES(40), .CNT_W(6)) dut (
      .clock        (clock),
      .reset        (reset),
      .valid        (valid),
      .opcode       (opcode),
      .aluop        (aluop),
      .rd           (rd),
      .operandA     (operandA),
      .operandB     (operandB),
      .flush        (flush),
      .md_ctrl_mult (md_ctrl_mult),
      .md_ctrl_div  (md_ctrl_div),
      .md_opA       (md_opA),
      .md_opB       (md_opB),
      .md_result    (md_result),
      .md_exception (md_exception),
      .md_resultRDY (md_resultRDY),
      .stall        (stall),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .timeout      (timeout)
   );

   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int mult_n = 0, div_n = 0, overlap_n = 0, stall_n = 0, wb_n = 0, to_n = 0, pulse_n = 0;
   int to_cyc = 0;
   int pulse_cyc [32];
   int wb_cyc [32];
   logic [4:0]  wb_rd_log [32];
   logic [31:0] wb_data_log [32];
   int m0, d0, s0, w0, t0, p0, o0;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (md_ctrl_mult && md_ctrl_div) overlap_n++;
      if (md_ctrl_mult || md_ctrl_div) begin
         if (pulse_n < 32) pulse_cyc[pulse_n] = cyc;
         pulse_n++;
      end
      if (md_ctrl_mult) mult_n++;
      if (md_ctrl_div) div_n++;
      if (stall) stall_n++;
      if (wb_valid) begin
         if (wb_n < 32) begin
            wb_cyc[wb_n]      = cyc;
            wb_rd_log[wb_n]   = wb_rd;
            wb_data_log[wb_n] = wb_data;
         end
         wb_n++;
      end
      if (timeout) begin
         to_n++;
         to_cyc = cyc;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic snap;
      m0 = mult_n; d0 = div_n; s0 = stall_n; w0 = wb_n; t0 = to_n; p0 = pulse_n; o0 = overlap_n;
   endtask

   // Present one instruction for its IDLE cycle; returns in the ISSUE cycle.
   task automatic present(input logic [4:0] op, input logic [4:0] dst,
                          input logic [31:0] a, input logic [31:0] b);
      valid = 1'b1; opcode = OP_RTYPE; aluop = op; rd = dst; operandA = a; operandB = b;
      tick();
      valid = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clock);
      #1;
      check_eq("rst_stall", stall, 0);
      check_eq("rst_wb_valid", wb_valid, 0);
      check_eq("rst_wb_rd", wb_rd, 0);
      check_eq("rst_wb_data", wb_data, 0);
      check_eq("rst_opA", md_opA, 0);
      check_eq("rst_ctrl", {md_ctrl_mult, md_ctrl_div, timeout}, 0);
      reset = 1'b1;
      tick();

      // mul rd=7, 6*7, ready 17 cycles after ISSUE
      snap();
      present(AOP_MUL, 5'd7, 32'd6, 32'd7);
      check_eq("t1_opA", md_opA, 6);
      check_eq("t1_opB", md_opB, 7);
      repeat (17) tick();
      md_resultRDY = 1'b1; md_result = 32'd42;
      tick();
      md_resultRDY = 1'b0;
      tick();
      check_eq("t1_mult_pulses", mult_n - m0, 1);
      check_eq("t1_div_pulses", div_n - d0, 0);
      check_eq("t1_stall_cycles", stall_n - s0, 19);
      check_eq("t1_wb_count", wb_n - w0, 1);
      check_eq("t1_wb_rd", wb_rd_log[w0], 7);
      check_eq("t1_wb_data", wb_data_log[w0], 42);
      check_eq("t1_latency", wb_cyc[w0] - pulse_cyc[p0], 18);

      // div by zero, unit reports exception
      snap();
      present(AOP_DIV, 5'd3, 32'd9, 32'd0);
      repeat (4) tick();
      md_resultRDY = 1'b1; md_exception = 1'b1; md_result = 32'd123;
      tick();
      md_resultRDY = 1'b0; md_exception = 1'b0;
      tick();
      check_eq("t2_wb_count", wb_n - w0, 1);
      check_eq("t2_wb_rd", wb_rd_log[w0], 30);
      check_eq("t2_wb_data", wb_data_log[w0], 5);
      check_eq("t2_mult_pulses", mult_n - m0, 0);
      check_eq("t2_div_pulses", div_n - d0, 1);
      check_eq("t2_no_timeout", to_n - t0, 0);

      // mul, unit never answers
      snap();
      present(AOP_MUL, 5'd4, 32'd3, 32'd5);
      for (int i = 0; i < 60 && wb_n == w0; i++) tick();
      check_eq("t3_wb_count", wb_n - w0, 1);
      check_eq("t3_timeout_pulses", to_n - t0, 1);
      check_eq("t3_wb_rd", wb_rd_log[w0], 30);
      check_eq("t3_wb_data", wb_data_log[w0], 4);
      check_eq("t3_timeout_to_wb", wb_cyc[w0] - to_cyc, 1);
      check_eq("t3_wb_latency", wb_cyc[w0] - pulse_cyc[p0], 41);
      check_eq("t3_stall_cycles", stall_n - s0, 42);
      check_eq("t3_stall_after", stall, 0);

      // div flushed in its fifth BUSY cycle, late ready afterwards
      snap();
      present(AOP_DIV, 5'd9, 32'd100, 32'd7);
      repeat (5) tick();
      flush = 1'b1;
      #1;
      check_eq("t4_stall_in_flush", stall, 1);
      tick();
      flush = 1'b0;
      check_eq("t4_stall_after_flush", stall, 0);
      repeat (3) tick();
      md_resultRDY = 1'b1; md_result = 32'd77;
      tick();
      md_resultRDY = 1'b0;
      repeat (3) tick();
      check_eq("t4_wb_count", wb_n - w0, 0);
      check_eq("t4_div_pulses", div_n - d0, 1);
      check_eq("t4_stall_cycles", stall_n - s0, 7);

      // back-to-back mul rd=1 then div rd=2, flush during first DONE
      snap();
      present(AOP_MUL, 5'd1, 32'd3, 32'd4);
      repeat (3) tick();
      md_resultRDY = 1'b1; md_result = 32'd12;
      tick();
      md_resultRDY = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      present(AOP_DIV, 5'd2, 32'd20, 32'd5);
      repeat (4) tick();
      md_resultRDY = 1'b1; md_result = 32'd4;
      tick();
      md_resultRDY = 1'b0;
      tick();
      check_eq("t5_wb_count", wb_n - w0, 2);
      check_eq("t5_wb0_rd", wb_rd_log[w0], 1);
      check_eq("t5_wb0_data", wb_data_log[w0], 12);
      check_eq("t5_wb1_rd", wb_rd_log[w0 + 1], 2);
      check_eq("t5_wb1_data", wb_data_log[w0 + 1], 4);
      check_eq("t5_second_start", pulse_cyc[p0 + 1] - wb_cyc[w0], 2);
      check_eq("t5_pulses", {mult_n - m0, div_n - d0}, {32'd1, 32'd1});
      check_eq("t5_overlap", overlap_n - o0, 0);

      // flush while a request sits in IDLE, then mul to r0
      snap();
      valid = 1'b1; opcode = OP_RTYPE; aluop = AOP_MUL; rd = 5'd5; flush = 1'b1;
      #1;
      check_eq("t6_stall_flush_idle", stall, 0);
      tick();
      valid = 1'b0; flush = 1'b0;
      tick();
      check_eq("t6_no_accept", mult_n - m0, 0);
      present(AOP_MUL, 5'd0, 32'd2, 32'd2);
      repeat (2) tick();
      md_resultRDY = 1'b1; md_result = 32'd4;
      tick();
      md_resultRDY = 1'b0;
      tick();
      check_eq("t6_r0_no_wb", wb_n - w0, 0);
      check_eq("t6_r0_pulse", mult_n - m0, 1);

      // asynchronous reset in BUSY
      snap();
      present(AOP_MUL, 5'd5, 32'd6, 32'd7);
      repeat (3) tick();
      #2;
      reset = 1'b0;
      #1;
      check_eq("t7_rst_stall", stall, 0);
      check_eq("t7_rst_opA", md_opA, 0);
      check_eq("t7_rst_opB", md_opB, 0);
      check_eq("t7_rst_outs", {md_ctrl_mult, md_ctrl_div, wb_valid, timeout, wb_rd}, 0);
      @(posedge clock);
      #3;
      reset = 1'b1;
      tick();
      md_resultRDY = 1'b1; md_result = 32'd30;
      tick();
      md_resultRDY = 1'b0;
      repeat (3) tick();
      check_eq("t7_no_wb", wb_n - w0, 0);
      check_eq("t7_pulses", mult_n - m0, 1);
      check_eq("t7_no_timeout", to_n - t0, 0);
      check_eq("t7_stall_idle", stall, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
